// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the multi-port register file.
package reg_file_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int NUM_RD_DEF   = 2;
    localparam int NUM_WR_DEF   = 1;
    localparam int ZERO_REG_DEF = 1;
    localparam int DEPTH        = 2 ** ADDR_W_DEF;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/reg_file_clear_seq.sv
// Post-reset clear sequencer: walks every entry writing zero, then raises ready.
module reg_file_clear_seq
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              ready
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] cnt_nxt;
    logic              ready_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            ready   <= 1'b0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= cnt_nxt;
            ready   <= ready_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = clr_cnt;
        ready_nxt = ready;
        unique case (state)
            CLEAR: begin
                cnt_nxt = clr_cnt + 1'b1;
                if (clr_cnt == {ADDR_W{1'b1}}) begin
                    state_nxt = RUN;
                    ready_nxt = 1'b1;
                end
            end
            RUN: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = CLEAR;
            end
        endcase
    end

    always_comb begin
        clr_we   = (state == CLEAR) && !reset;
        clr_addr = clr_cnt;
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with hardware clear, optional zero register
// and same-cycle write-to-read bypass.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int NUM_WR   = NUM_WR_DEF,
    parameter int ZERO_REG = ZERO_REG_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    output logic                     ready
);

    localparam int ENTRIES = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [ENTRIES];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              accept;

    reg_file_clear_seq #(
        .ADDR_W(ADDR_W)
    ) u_clear_seq (
        .clk     (clk),
        .reset   (reset),
        .clr_we  (clr_we),
        .clr_addr(clr_addr),
        .ready   (ready)
    );

    // User writes only land once the clear has finished and not under reset.
    assign accept = ready && !reset;

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (accept) begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] &&
                    !(ZERO_REG != 0 &&
                      wr_addr[w*ADDR_W +: ADDR_W] == '0)) begin
                    mem[wr_addr[w*ADDR_W +: ADDR_W]] <=
                        wr_data[w*DATA_W +: DATA_W];
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] val;

        assign addr = rd_addr[p*ADDR_W +: ADDR_W];

        // Ascending scan lets the highest-indexed matching port win.
        always_comb begin
            val = mem[addr];
            for (int w = 0; w < NUM_WR; w++) begin
                if (accept && wr_en[w] &&
                    wr_addr[w*ADDR_W +: ADDR_W] == addr) begin
                    val = wr_data[w*DATA_W +: DATA_W];
                end
            end
            if ((ZERO_REG != 0 && addr == '0) || !ready) begin
                val = '0;
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = val;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp (4 read, 2 write ports).
module tb_reg_file_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 4;
    localparam int NW = 2;

    logic             clk;
    logic             reset;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NW-1:0]    wr_en;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*DW-1:0] wr_data;
    logic             ready;

    int errors;
    int checks;

    reg_file_mp #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .NUM_RD  (NR),
        .NUM_WR  (NW),
        .ZERO_REG(1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .ready  (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic set_wr(input int w, input logic en,
                          input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
        wr_en[w]            = en;
        wr_addr[w*AW +: AW] = a;
        wr_data[w*DW +: DW] = d;
    endtask

    function automatic logic [DW-1:0] rd(input int p);
        return rd_data[p*DW +: DW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Release reset and check ready only rises on the 32nd edge.
    task automatic run_clear(input string tag);
        logic exp;
        for (int e = 1; e <= 32; e++) begin
            tick();
            exp = (e == 32);
            checks++;
            if (ready !== exp) begin
                errors++;
                $display("FAIL %s ready edge %0d: got %b want %b",
                         tag, e, ready, exp);
            end
            if (e < 32) begin
                checks++;
                if (rd(0) !== 32'h0) begin
                    errors++;
                    $display("FAIL %s rd0 in clear edge %0d: got %h want 0",
                             tag, e, rd(0));
                end
            end
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        rd_addr = '0;
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;
        repeat (3) tick();
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL reset ready: got %b want 0", ready);
        end
        // Hammer r2 during the clear; these writes must all be dropped.
        set_wr(0, 1'b1, 5'd2, 32'hFFFF_FFFF);
        set_rd(0, 5'd2);
        reset = 1'b0;
        run_clear("init");
        set_wr(0, 1'b0, 5'd0, 32'h0);
        for (int a = 0; a < 32; a += NR) begin
            for (int p = 0; p < NR; p++) set_rd(p, 5'(a + p));
            #1;
            for (int p = 0; p < NR; p++) begin
                checks++;
                if (rd(p) !== 32'h0) begin
                    errors++;
                    $display("FAIL cleared r%0d: got %h want 0",
                             a + p, rd(p));
                end
            end
        end
    endtask

    task automatic test_bypass();
        set_wr(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        set_rd(0, 5'd5);
        #1;
        checks++;
        if (rd(0) !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL bypass r5: got %h want deadbeef", rd(0));
        end
        tick();
        set_wr(0, 1'b0, 5'd0, 32'h0);
        #1;
        checks++;
        if (rd(0) !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL stored r5: got %h want deadbeef", rd(0));
        end
    endtask

    task automatic test_zero_reg();
        set_wr(0, 1'b1, 5'd0, 32'h1234_5678);
        set_rd(0, 5'd0);
        #1;
        checks++;
        if (rd(0) !== 32'h0) begin
            errors++;
            $display("FAIL r0 bypass: got %h want 0", rd(0));
        end
        tick();
        set_wr(0, 1'b0, 5'd0, 32'h0);
        #1;
        checks++;
        if (rd(0) !== 32'h0) begin
            errors++;
            $display("FAIL r0 stored: got %h want 0", rd(0));
        end
    endtask

    task automatic test_dual_write();
        set_wr(0, 1'b1, 5'd7, 32'h1);
        set_wr(1, 1'b1, 5'd7, 32'h2);
        set_rd(0, 5'd7);
        #1;
        checks++;
        if (rd(0) !== 32'h2) begin
            errors++;
            $display("FAIL dual bypass r7: got %h want 2", rd(0));
        end
        tick();
        set_wr(0, 1'b1, 5'd8, 32'h11);
        set_wr(1, 1'b1, 5'd10, 32'h22);
        #1;
        checks++;
        if (rd(0) !== 32'h2) begin
            errors++;
            $display("FAIL dual stored r7: got %h want 2", rd(0));
        end
        tick();
        set_wr(0, 1'b0, 5'd0, 32'h0);
        set_wr(1, 1'b0, 5'd0, 32'h0);
        set_rd(0, 5'd8);
        set_rd(1, 5'd10);
        #1;
        checks++;
        if (rd(0) !== 32'h11) begin
            errors++;
            $display("FAIL dual port0 r8: got %h want 11", rd(0));
        end
        checks++;
        if (rd(1) !== 32'h22) begin
            errors++;
            $display("FAIL dual port1 r10: got %h want 22", rd(1));
        end
    endtask

    task automatic test_multi_read();
        set_wr(1, 1'b1, 5'd9, 32'hA5A5_A5A5);
        tick();
        set_wr(1, 1'b0, 5'd0, 32'h0);
        for (int p = 0; p < NR; p++) set_rd(p, 5'd9);
        #1;
        for (int p = 0; p < NR; p++) begin
            checks++;
            if (rd(p) !== 32'hA5A5_A5A5) begin
                errors++;
                $display("FAIL multi read port %0d: got %h want a5a5a5a5",
                         p, rd(p));
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        for (int a = 1; a < 32; a++) begin
            set_wr(0, 1'b1, 5'(a), 32'(a));
            tick();
        end
        set_wr(0, 1'b0, 5'd0, 32'h0);
        set_rd(0, 5'd31);
        set_rd(1, 5'd17);
        #1;
        checks++;
        if (rd(0) !== 32'd31 || rd(1) !== 32'd17) begin
            errors++;
            $display("FAIL fill r31/r17: got %h/%h want 1f/11",
                     rd(0), rd(1));
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL mid-clear reset ready: got %b want 0", ready);
        end
        reset = 1'b0;
        set_rd(0, 5'd0);
        run_clear("restart");
        // Write issued in the first cycle ready is high must be kept.
        set_wr(1, 1'b1, 5'd4, 32'hCAFE_0004);
        tick();
        set_wr(1, 1'b0, 5'd0, 32'h0);
        set_rd(0, 5'd4);
        #1;
        checks++;
        if (rd(0) !== 32'hCAFE_0004) begin
            errors++;
            $display("FAIL first-ready write r4: got %h want cafe0004",
                     rd(0));
        end
        for (int a = 1; a < 32; a++) begin
            if (a == 4) continue;
            set_rd(1, 5'(a));
            #1;
            checks++;
            if (rd(1) !== 32'h0) begin
                errors++;
                $display("FAIL re-zeroed r%0d: got %h want 0", a, rd(1));
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_bypass();
        test_zero_reg();
        test_dual_write();
        test_multi_read();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
